// File: rtl/vip_pkg.sv
// +-------------------------------------------------------------------------+
// | vip_pkg: shared types and constants for the gray binarization stage.    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

package vip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_PEND = 2'd2
  } vip_state_e;

  localparam logic [7:0] BIN_HI = 8'hFF;
  localparam logic [7:0] BIN_LO = 8'h00;

  localparam int VIP_CNT_W = 22;
  localparam int VIP_SUM_W = 30;

  function automatic logic [7:0] clamp8(input logic [7:0] v,
                                        input logic [7:0] lo,
                                        input logic [7:0] hi);
    if (v < lo)      clamp8 = lo;
    else if (v > hi) clamp8 = hi;
    else             clamp8 = v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vip_seq_divider.sv
// +-------------------------------------------------------------------------+
// | vip_seq_divider: unsigned restoring divider, one quotient bit per clock.|
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module vip_seq_divider
  import vip_pkg::*;
#(
  parameter int DVD_W = VIP_SUM_W,
  parameter int DVS_W = VIP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [DVD_W-1:0] i_dividend,
  input  logic [DVS_W-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [DVD_W-1:0] o_quotient
);

  localparam int CW = $clog2(DVD_W + 1);

  logic [DVD_W-1:0] r_quo;
  logic [DVS_W-1:0] r_rem;
  logic [DVS_W-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [DVS_W:0]   w_shift;
  logic             w_ge;
  logic [DVS_W-1:0] w_sub;

  // Remainder stays below the divisor, so the difference always fits DVS_W bits.
  assign w_shift = {r_rem, r_quo[DVD_W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift[DVS_W-1:0] - r_dvs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_quo  <= i_dividend;
        r_rem  <= '0;
        r_dvs  <= i_divisor;
        r_cnt  <= CW'(DVD_W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_quo <= {r_quo[DVD_W-2:0], w_ge};
        r_rem <= w_ge ? w_sub : w_shift[DVS_W-1:0];
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule

`default_nettype wire

// File: rtl/vip_gray_adaptive_binarization.sv
// +-------------------------------------------------------------------------+
// | vip_gray_adaptive_binarization: binarizes gray video against the mean   |
// | luminance of the previous frame. Option: VIP_BIN_THRESH_CLAMP_EN.       |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module vip_gray_adaptive_binarization
  import vip_pkg::*;
#(
  parameter int         CNT_W       = VIP_CNT_W,
  parameter int         SUM_W       = VIP_SUM_W,
  parameter logic [7:0] THRESH_INIT = 8'd128,
  parameter logic [7:0] THRESH_MIN  = 8'd32,
  parameter logic [7:0] THRESH_MAX  = 8'd224
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pre_frame_vsync,
  input  logic       pre_frame_href,
  input  logic       pre_frame_clken,
  input  logic [7:0] pre_img_y,
  output logic       pos_frame_vsync,
  output logic       pos_frame_href,
  output logic       pos_frame_clken,
  output logic [7:0] pos_img_y,
  output logic [7:0] thresh_cur
);

  vip_state_e       r_state;
  vip_state_e       w_state_next;

  logic             r_vsync_d;
  logic             r_href_d;
  logic             r_clken_d;
  logic [7:0]       r_pos_y;
  logic [7:0]       r_thresh;
  logic [7:0]       r_thresh_new;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;

  logic             w_pix;
  logic             w_rise;
  logic             w_frame_ok;
  logic [SUM_W:0]   w_sum_add;
  logic [CNT_W:0]   w_cnt_add;
  logic [SUM_W-1:0] w_sum_sat;
  logic [CNT_W-1:0] w_cnt_sat;

  logic             w_div_start;
  logic             w_capture;
  logic             w_commit;
  logic             w_div_busy;
  logic             w_div_done;
  logic [SUM_W-1:0] w_quotient;
  logic [7:0]       w_q8;
  logic [7:0]       w_thresh_next;

  assign w_pix      = pre_frame_clken & pre_frame_href;
  assign w_rise     = pre_frame_vsync & ~r_vsync_d;
  assign w_frame_ok = w_rise & (r_cnt != '0);

  // Accumulators saturate instead of wrapping on oversized frames.
  assign w_sum_add = {1'b0, r_sum} + (SUM_W+1)'(pre_img_y);
  assign w_cnt_add = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign w_sum_sat = w_sum_add[SUM_W] ? '1 : w_sum_add[SUM_W-1:0];
  assign w_cnt_sat = w_cnt_add[CNT_W] ? '1 : w_cnt_add[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (w_rise) begin
      r_sum <= w_pix ? SUM_W'(pre_img_y) : '0;
      r_cnt <= w_pix ? CNT_W'(1) : '0;
    end else if (w_pix) begin
      r_sum <= w_sum_sat;
      r_cnt <= w_cnt_sat;
    end
  end

  vip_seq_divider #(
    .DVD_W (SUM_W),
    .DVS_W (CNT_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_dividend (r_sum),
    .i_divisor  (r_cnt),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quotient)
  );

  // Mean of 8-bit samples never exceeds 255; the guard only covers impossible inputs.
  assign w_q8 = (|w_quotient[SUM_W-1:8]) ? 8'hFF : w_quotient[7:0];

`ifdef VIP_BIN_THRESH_CLAMP_EN
  assign w_thresh_next = clamp8(w_q8, THRESH_MIN, THRESH_MAX);
`else
  assign w_thresh_next = w_q8;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_rise) begin
      w_state_next = w_frame_ok ? ST_DIV : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_next = ST_IDLE;
        ST_DIV: begin
          if (w_div_done)       w_state_next = ST_PEND;
          else if (!w_div_busy) w_state_next = ST_IDLE;
        end
        ST_PEND: begin
          if (!pre_frame_href)  w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_div_start = w_frame_ok;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    if (!w_rise) begin
      w_capture = (r_state == ST_DIV) && w_div_done;
      w_commit  = (r_state == ST_PEND) && !pre_frame_href;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_thresh_new <= THRESH_INIT;
      r_thresh     <= THRESH_INIT;
    end else begin
      if (w_capture) r_thresh_new <= w_thresh_next;
      if (w_commit)  r_thresh     <= r_thresh_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
      r_clken_d <= 1'b0;
      r_pos_y   <= BIN_LO;
    end else begin
      r_vsync_d <= pre_frame_vsync;
      r_href_d  <= pre_frame_href;
      r_clken_d <= pre_frame_clken;
      r_pos_y   <= (pre_frame_href && (pre_img_y > r_thresh)) ? BIN_HI : BIN_LO;
    end
  end

  assign pos_frame_vsync = r_vsync_d;
  assign pos_frame_href  = r_href_d;
  assign pos_frame_clken = r_clken_d;
  assign pos_img_y       = r_href_d ? r_pos_y : BIN_LO;
  assign thresh_cur      = r_thresh;

endmodule

`default_nettype wire

// File: tb/tb_vip_gray_adaptive_binarization.sv
// +-------------------------------------------------------------------------+
// | tb_vip_gray_adaptive_binarization: scoreboard bench for the binarizer.  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_vip_gray_adaptive_binarization;

  logic       clk;
  logic       rst_n;
  logic       pre_frame_vsync;
  logic       pre_frame_href;
  logic       pre_frame_clken;
  logic [7:0] pre_img_y;
  logic       pos_frame_vsync;
  logic       pos_frame_href;
  logic       pos_frame_clken;
  logic [7:0] pos_img_y;
  logic [7:0] thresh_cur;

`ifdef VIP_BIN_THRESH_CLAMP_EN
  localparam logic [7:0] T_C   = 8'd32;
  localparam logic [7:0] T_E   = 8'd32;
  localparam logic [7:0] E_EXP = 8'h00;
`else
  localparam logic [7:0] T_C   = 8'd1;
  localparam logic [7:0] T_E   = 8'd10;
  localparam logic [7:0] E_EXP = 8'hFF;
`endif

  int total;
  int bad;
  logic [7:0] sb[$];

  vip_gray_adaptive_binarization u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pre_frame_vsync (pre_frame_vsync),
    .pre_frame_href  (pre_frame_href),
    .pre_frame_clken (pre_frame_clken),
    .pre_img_y       (pre_img_y),
    .pos_frame_vsync (pos_frame_vsync),
    .pos_frame_href  (pos_frame_href),
    .pos_frame_clken (pos_frame_clken),
    .pos_img_y       (pos_img_y),
    .thresh_cur      (thresh_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every output pixel strobe consumes one expected value.
  always @(negedge clk) begin
    if (pos_frame_clken) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pixel got=%h exp=none", pos_img_y);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (pos_img_y !== e) begin
          bad++;
          $display("FAIL pixel got=%h exp=%h", pos_img_y, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic pix(input logic [7:0] y, input logic [7:0] e);
    pre_frame_href  = 1'b1;
    pre_frame_clken = 1'b1;
    pre_img_y       = y;
    sb.push_back(e);
    tick();
  endtask

  task automatic gap(input int n);
    pre_frame_href  = 1'b0;
    pre_frame_clken = 1'b0;
    pre_img_y       = 8'd0;
    repeat (n) tick();
  endtask

  // Raise vsync with href low and wait a bounded time for the new threshold.
  task automatic vsync_wait(input string name, input logic [7:0] exp);
    gap(2);
    pre_frame_vsync = 1'b1;
    tick();
    tick();
    pre_frame_vsync = 1'b0;
    for (int i = 0; i < 33; i++) begin
      if (thresh_cur == exp) break;
      tick();
    end
    check(name, thresh_cur, exp);
    gap(3);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    pre_frame_vsync = 1'b0;
    pre_frame_href  = 1'b0;
    pre_frame_clken = 1'b0;
    pre_img_y       = 8'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_thresh", thresh_cur, 8'd128);
    check("reset_pos", {pos_frame_vsync, pos_frame_href, pos_frame_clken, pos_img_y}, 0);

    // Equality boundary against the initial threshold.
    pix(8'd128, 8'h00);
    pix(8'd129, 8'hFF);
    gap(2);
    check("init_thresh", thresh_cur, 8'd128);
    vsync_wait("mean_128_129", 8'd128);

    // 4x4 frame: two lines of 0, two lines of 200.
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 4; p++) pix((l < 2) ? 8'd0 : 8'd200, (l < 2) ? 8'h00 : 8'hFF);
      gap(2);
    end
    vsync_wait("mean_4x4", 8'd100);

    pix(8'd100, 8'h00);
    pix(8'd101, 8'hFF);
    vsync_wait("mean_100_101", 8'd100);

    pix(8'd1, 8'h00);
    pix(8'd1, 8'h00);
    pix(8'd2, 8'h00);
    vsync_wait("mean_truncated", T_C);

    // Empty frame keeps the threshold.
    gap(2);
    pre_frame_vsync = 1'b1;
    repeat (3) tick();
    pre_frame_vsync = 1'b0;
    gap(40);
    check("empty_frame", thresh_cur, T_C);

    for (int p = 0; p < 4; p++) pix(8'd10, E_EXP);
    vsync_wait("mean_10_clamp", T_E);

    // Vsync while href stays high: commit must wait for href to fall.
    pix(8'd50, 8'hFF);
    pix(8'd50, 8'hFF);
    pre_frame_clken = 1'b0;
    repeat (2) tick();
    pre_frame_vsync = 1'b1;
    repeat (3) tick();
    pre_frame_vsync = 1'b0;
    repeat (35) tick();
    check("hold_old_thresh", thresh_cur, T_E);
    pix(8'd40, 8'hFF);
    pix(8'd40, 8'hFF);
    gap(3);
    check("commit_after_href", thresh_cur, 8'd50);

    // Frame with 40,40,100,100 interrupted by reset mid-division.
    pix(8'd100, 8'hFF);
    pix(8'd100, 8'hFF);
    gap(2);
    pre_frame_vsync = 1'b1;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pre_frame_vsync = 1'b0;
    check("rst_mid_div_thresh", thresh_cur, 8'd128);
    check("rst_mid_div_pos", {pos_frame_vsync, pos_frame_href, pos_frame_clken, pos_img_y}, 0);
    gap(40);
    check("no_partial_commit", thresh_cur, 8'd128);

    pix(8'd60, 8'h00);
    pix(8'd60, 8'h00);
    pix(8'd61, 8'h00);
    vsync_wait("mean_after_reset", 8'd60);
    pix(8'd60, 8'h00);
    pix(8'd61, 8'hFF);
    gap(3);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
